popcnt_sched: RTL and testbench

//  Round-robin scheduler that shares one popcnt12 one-hot population-count unit among NREQ requesters.

---
 rtl/popcnt_sched_pkg.sv | 33 +++
 rtl/popcnt12.sv | 29 ++
 rtl/popcnt_sched.sv | 126 ++++++++++++
 tb/tb_popcnt_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcnt_sched_pkg.sv
// Shared types and one-hot helpers for the popcount scheduler.
// No logic of its own; functions are purely combinational.
// Helpers work on a fixed ceiling width; callers zero-extend and truncate.
package popcnt_sched_pkg;

    localparam int CHUNK_W = 12;
    localparam int PC_W    = CHUNK_W + 1;
    // Ceiling for the helper functions; supports WIDTH up to 1024.
    localparam int OH_MAX  = 1025;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Adding counts in one-hot form is a shift of a by every set position of b.
    function automatic logic [OH_MAX-1:0] onehot_conv(input logic [OH_MAX-1:0] a,
                                                      input logic [PC_W-1:0]   b);
        logic [OH_MAX-1:0] r;
        r = '0;
        for (int j = 0; j < PC_W; j++) begin
            if (b[j]) r |= a << j;
        end
        return r;
    endfunction

    function automatic int onehot2bin(input logic [OH_MAX-1:0] a);
        int r;
        r = 0;
        for (int k = 0; k < OH_MAX; k++) begin
            if (a[k]) r |= k;
        end
        return r;
    endfunction

endpackage

// File: rtl/popcnt12.sv
// One-hot population count of a 12-bit chunk, built from two 6-bit halves.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
module popcnt12
    import popcnt_sched_pkg::*;
(
    input  logic [CHUNK_W-1:0] din,
    output logic [PC_W-1:0]    onehot
);

    logic [2:0] lo_cnt, hi_cnt;
    logic [6:0] lo_oh, hi_oh;

    always_comb begin
        lo_cnt = '0;
        hi_cnt = '0;
        for (int i = 0; i < 6; i++) begin
            lo_cnt = lo_cnt + {2'b00, din[i]};
            hi_cnt = hi_cnt + {2'b00, din[i+6]};
        end
        lo_oh  = 7'(1) << lo_cnt;
        hi_oh  = 7'(1) << hi_cnt;
        onehot = '0;
        for (int j = 0; j < 7; j++) begin
            if (hi_oh[j]) onehot |= 13'(lo_oh) << j;
        end
    end

endmodule

// File: rtl/popcnt_sched.sv
// Round-robin share of one popcnt12 among NREQ requesters; optional POPCNT_SCHED_BIN_EN adds res_count.
// Latency: accept at cycle T gives res_valid at T+NCH+1; one request per NCH+2 cycles at best.
// Backpressure: result held stable while res_ready is low; no new grant until the result drains.
module popcnt_sched
    import popcnt_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 48,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH:0]        res_onehot,
`ifdef POPCNT_SCHED_BIN_EN
    output logic [CW-1:0]         res_count,
`endif
    output logic                  busy
);

    localparam int NCH = WIDTH / CHUNK_W;
    localparam int OW  = WIDTH + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_vld;
    logic [WIDTH-1:0]   shadow;
    logic [CHW-1:0]     chunk;
    logic [OW-1:0]      acc;
    logic [OW-1:0]      acc_nxt;
    logic [CHUNK_W-1:0] pc_in;
    logic [PC_W-1:0]    pc_out;
    logic [OH_MAX-1:0]  acc_ext;
    logic [OH_MAX-1:0]  conv_full;
    logic               unused_conv_hi;
    int                 idx;

    // Scan downwards so the requester closest to rr_ptr is the last (winning) write.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    assign pc_in = shadow[int'(chunk)*CHUNK_W +: CHUNK_W];

    popcnt12 u_popcnt12 (
        .din    (pc_in),
        .onehot (pc_out)
    );

    always_comb begin
        acc_ext          = '0;
        acc_ext[OW-1:0]  = acc;
        conv_full        = onehot_conv(acc_ext, pc_out);
        acc_nxt          = conv_full[OW-1:0];
    end

    assign unused_conv_hi = ^conv_full[OH_MAX-1:OW];

    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign res_onehot = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            shadow    <= '0;
            chunk     <= '0;
            acc       <= '0;
            res_id    <= '0;
`ifdef POPCNT_SCHED_BIN_EN
            res_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        shadow <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
                        res_id <= gnt_idx;
                        acc    <= OW'(1);
                        chunk  <= '0;
                        rr_ptr <= IDW'((int'(gnt_idx) + 1) % NREQ);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    chunk <= chunk + CHW'(1);
                    if (chunk == CHW'(NCH - 1)) begin
                        state     <= DONE;
`ifdef POPCNT_SCHED_BIN_EN
                        res_count <= CW'(onehot2bin(conv_full));
`endif
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcnt_sched.sv
// Directed and randomized checks of popcnt_sched against a cycle-level transaction model.
// The model tracks grant order, result timing and expected counts from popcount arithmetic.
module tb_popcnt_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 48;
    localparam int NCH   = WIDTH / 12;
    localparam int IDW   = 2;
    localparam int OW    = WIDTH + 1;
    localparam int CW    = $clog2(WIDTH + 1);

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH:0]        res_onehot;
    logic                  busy;
`ifdef POPCNT_SCHED_BIN_EN
    logic [CW-1:0]         res_count;
`endif

    popcnt_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_onehot (res_onehot),
`ifdef POPCNT_SCHED_BIN_EN
        .res_count  (res_count),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass = 0;
    int ntot  = 0;

    // Stimulus state and transaction model
    logic [WIDTH-1:0] d [NREQ];
    logic             v [NREQ];
    int               mptr   = 0;
    bit               m_busy = 0;
    int               m_left = 0;
    int               m_id   = 0;
    int               m_cnt  = 0;
    int               gq[$];
    int               cq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [OW-1:0] oh_of_cnt(input int cnt);
        logic [OW-1:0] one;
        one = 1;
        return one << cnt;
    endfunction

    function automatic logic [WIDTH-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            default: return t[WIDTH-1:0];
        endcase
    endfunction

    function automatic int pick();
        int k;
        for (int i = 0; i < NREQ; i++) begin
            k = (mptr + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                = v[i];
            req_data[i*WIDTH +: WIDTH]  = d[i];
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        apply();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_onehot", res_onehot, 0);
        chk("rst_busy", busy, 0);
`ifdef POPCNT_SCHED_BIN_EN
        chk("rst_res_count", res_count, 0);
`endif
        rst_n  = 1'b1;
        mptr   = 0;
        m_busy = 0;
        gq.delete();
        cq.delete();
    endtask

    // One isolated request; expected count supplied by the caller.
    task automatic single(input int id, input logic [WIDTH-1:0] dat, input int cnt);
        int n;
        res_ready = 1'b1;
        d[id] = dat;
        v[id] = 1'b1;
        apply();
        #1;
        chk("single_grant", req_ready, 1 << id);
        @(posedge clk); #1;
        v[id] = 1'b0;
        apply();
        mptr = (id + 1) % NREQ;
        @(negedge clk);
        chk("single_ready_low", req_ready, 0);
        chk("single_busy", busy, 1);
        n = 1;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", n, NCH + 1);
        chk("single_res_id", res_id, id);
        chk("single_onehot", res_onehot, oh_of_cnt(cnt));
`ifdef POPCNT_SCHED_BIN_EN
        chk("single_count", res_count, cnt);
`endif
        @(negedge clk);
        chk("single_drained", res_valid, 0);
    endtask

    // mode 0: everyone stays valid; 1: random valids; 2: valids dropped.
    task automatic traffic(input int ncyc, input int mode, input bit rnd_rdy);
        int g;
        logic [NREQ-1:0] exp_rdy;
        for (int c = 0; c < ncyc; c++) begin
            res_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
            #1;
            g = m_busy ? -1 : pick();
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("tr_req_ready", req_ready, exp_rdy);
            chk("tr_busy", busy, m_busy);
            chk("tr_res_valid", res_valid, m_busy && m_left == 0);
            if (m_busy && m_left == 0) begin
                chk("tr_res_id", res_id, m_id);
                chk("tr_res_onehot", res_onehot, oh_of_cnt(m_cnt));
`ifdef POPCNT_SCHED_BIN_EN
                chk("tr_res_count", res_count, m_cnt);
`endif
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                m_busy = 1;
                m_left = NCH;
                m_id   = g;
                m_cnt  = $countones(d[g]);
                mptr   = (g + 1) % NREQ;
                gq.push_back(g);
                cq.push_back(cyc);
                d[g] = rnd48();
                v[g] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'b0;
            end else if (m_busy) begin
                if (m_left > 0) m_left--;
                else if (res_ready) m_busy = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (i != g) begin
                    if (mode == 2) v[i] = 1'b0;
                    else if (mode == 1) begin
                        if (!v[i]) begin
                            if ($urandom % 4 == 0) begin
                                v[i] = 1'b1;
                                d[i] = rnd48();
                            end
                        end else if ($urandom % 8 == 0) v[i] = 1'b0;
                    end
                end
            end
            apply();
            @(negedge clk);
        end
    endtask

    initial begin
        int g, n;
        int exp_order[5];
        logic [WIDTH-1:0] t3;
        logic [WIDTH-1:0] dat;

        exp_order = '{0, 1, 2, 3, 0};
        t3 = 48'h0F0_000_001_FFF;

        // Reset values
        do_reset();

        // Directed single requests: all ones, all zero, mixed chunks
        single(2, '1, 48);
        single(0, '0, 0);
        single(1, t3, 17);
        for (int k = 0; k < 8; k++) begin
            dat = rnd48();
            single(int'($urandom % NREQ), dat, $countones(dat));
        end

        // All requesters held valid from reset: strict rotation at peak rate
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            d[i] = rnd48();
        end
        apply();
        traffic(40, 0, 0);
        chk("rot_grant_count", gq.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk("rot_order", gq[i], exp_order[i]);
        end
        if (cq.size() >= 2) chk("rot_spacing", cq[1] - cq[0], NCH + 2);
        traffic(12, 2, 0);

        // Result backpressure with other requesters pending
        res_ready = 1'b0;
        v[1] = 1'b1;
        v[3] = 1'b1;
        d[1] = rnd48();
        d[3] = rnd48();
        apply();
        g = pick();
        #1;
        chk("bp_grant", req_ready, 1 << g);
        @(posedge clk); #1;
        v[g] = 1'b0;
        mptr = (g + 1) % NREQ;
        apply();
        @(negedge clk);
        n = 1;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", n, NCH + 1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_id", res_id, g);
            chk("bp_res_onehot", res_onehot, oh_of_cnt($countones(d[g])));
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        apply();
        @(negedge clk);
        chk("bp_one_handshake", res_valid, 0);
        chk("bp_idle", busy, 0);

        // Reset in the middle of a computation
        v[2] = 1'b1;
        d[2] = rnd48();
        apply();
        #1;
        chk("mid_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        v[2] = 1'b0;
        apply();
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_onehot", res_onehot, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mptr   = 0;
        m_busy = 0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            d[i] = rnd48();
        end
        apply();
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        traffic(30, 0, 0);
        traffic(12, 2, 0);

        // Random traffic with random result backpressure
        traffic(2000, 1, 1);
        traffic(20, 2, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
